// File: rtl/rtc_bus_seq_if.sv
// RTC register bus as seen by the sequencer. One write or read strobe per word;
// read data returns on the cycle after its strobe.
interface rtc_bus_seq_if;
  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic        m_wr_ce_o;
  logic        m_rd_ce_o;
  logic [31:0] m_rdata_i;

  modport master (
    output m_addr_o,
    output m_data_o,
    output m_wr_ce_o,
    output m_rd_ce_o,
    input  m_rdata_i
  );

  modport slave (
    input  m_addr_o,
    input  m_data_o,
    input  m_wr_ce_o,
    input  m_rd_ce_o,
    output m_rdata_i
  );
endinterface

// File: rtl/rtc_bus_seq.sv
// RTC bus sequencer: offset-apply writes (ack at grant+5+GUARD_CYC) and time-snapshot reads (done at grant+5, or grant+7 per attempt with RTC_SNAP_COHERENT_EN).
// Requests are level and only sampled in IDLE; the slave never stalls, so the bus has no backpressure.
module rtc_bus_seq #(
  parameter int          GUARD_CYC    = 3,
  parameter int          MAX_TRY      = 4,
  parameter logic [23:0] RTC_BLK_ADDR = 24'h00_4000
) (
  input  logic          bus2ip_clk,
  input  logic          bus2ip_rst_n,
  input  logic          ofst_req_i,
  input  logic [47:0]   ofst_sc_i,
  input  logic [31:0]   ofst_ns_i,
  input  logic          intxms_sel_i,
  output logic          ofst_ack_o,
  input  logic          snap_req_i,
  output logic [79:0]   snap_std_o,
  output logic [15:0]   snap_fns_o,
  output logic          snap_done_o,
  output logic          snap_err_o,
  rtc_bus_seq_if.master bus
);

  localparam logic [7:0] RTC_CTL_ADDR  = 8'h00;
  localparam logic [7:0] NS_OFST_ADDR  = 8'h10;
  localparam logic [7:0] SC_OFST_ADDR0 = 8'h14;
  localparam logic [7:0] SC_OFST_ADDR1 = 8'h18;
  localparam logic [7:0] CUR_TM_ADDR0  = 8'h20;
  localparam logic [7:0] CUR_TM_ADDR1  = 8'h24;
  localparam logic [7:0] CUR_TM_ADDR2  = 8'h28;

  localparam int GW = (GUARD_CYC < 2) ? 1 : $clog2(GUARD_CYC);

  if (GUARD_CYC < 0 || MAX_TRY < 1) begin : g_bad_param
    $error("rtc_bus_seq: GUARD_CYC must be >= 0 and MAX_TRY >= 1");
  end

  typedef enum logic [3:0] {
    IDLE, OW0, OW1, OW2, OWC, GUARD, OACK,
    SR0, SR1, SR2,
`ifdef RTC_SNAP_COHERENT_EN
    SC0, SC1,
`endif
    SCAP, SDONE
  } state_t;

  state_t          state_q, state_d;
  logic            last_snap_q;
  logic            grant_ofst, grant_snap;
  logic [47:0]     sc_q;
  logic [31:0]     ns_q;
  logic [GW-1:0]   guard_q;
  logic [79:0]     std_q;
  logic [15:0]     fns_q;
  logic [31:0]     addr_d, data_d;
  logic [7:0]      ofs_d;
  logic            wr_d, rd_d;

`ifdef RTC_SNAP_COHERENT_EN
  localparam int TW = (MAX_TRY < 2) ? 1 : $clog2(MAX_TRY);
  logic          mism0_q;
  logic [TW-1:0] try_q;
  logic          err_q;
  logic          attempt_fail;
  logic          try_last;

  assign attempt_fail = mism0_q || (bus.m_rdata_i != std_q[47:16]);
  assign try_last     = (try_q == TW'(MAX_TRY - 1));
`endif

  always_comb begin
    state_d    = state_q;
    grant_ofst = 1'b0;
    grant_snap = 1'b0;
    ofs_d      = 8'h00;
    data_d     = 32'h0;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // Round-robin on a tie: whichever kind was not granted last wins.
        if (ofst_req_i && (!snap_req_i || last_snap_q)) begin
          grant_ofst = 1'b1;
          state_d    = OW0;
        end else if (snap_req_i) begin
          grant_snap = 1'b1;
          state_d    = SR0;
        end
      end
      OW0: begin
        wr_d    = 1'b1;
        ofs_d   = SC_OFST_ADDR0;
        data_d  = {16'h0, sc_q[47:32]};
        state_d = OW1;
      end
      OW1: begin
        wr_d    = 1'b1;
        ofs_d   = SC_OFST_ADDR1;
        data_d  = sc_q[31:0];
        state_d = OW2;
      end
      OW2: begin
        wr_d    = 1'b1;
        ofs_d   = NS_OFST_ADDR;
        data_d  = ns_q;
        state_d = OWC;
      end
      OWC: begin
        wr_d    = 1'b1;
        ofs_d   = RTC_CTL_ADDR;
        data_d  = {29'h0, intxms_sel_i, 1'b0, 1'b1};
        state_d = (GUARD_CYC == 0) ? OACK : GUARD;
      end
      GUARD: begin
        if (guard_q == '0) state_d = OACK;
      end
      OACK:  state_d = IDLE;
      SR0: begin
        rd_d    = 1'b1;
        ofs_d   = CUR_TM_ADDR0;
        state_d = SR1;
      end
      SR1: begin
        rd_d    = 1'b1;
        ofs_d   = CUR_TM_ADDR1;
        state_d = SR2;
      end
      SR2: begin
        rd_d    = 1'b1;
        ofs_d   = CUR_TM_ADDR2;
`ifdef RTC_SNAP_COHERENT_EN
        state_d = SC0;
`else
        state_d = SCAP;
`endif
      end
`ifdef RTC_SNAP_COHERENT_EN
      SC0: begin
        rd_d    = 1'b1;
        ofs_d   = CUR_TM_ADDR0;
        state_d = SC1;
      end
      SC1: begin
        rd_d    = 1'b1;
        ofs_d   = CUR_TM_ADDR1;
        state_d = SCAP;
      end
      SCAP:  state_d = (attempt_fail && !try_last) ? SR0 : SDONE;
`else
      SCAP:  state_d = SDONE;
`endif
      SDONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    addr_d = (wr_d || rd_d) ? {RTC_BLK_ADDR, ofs_d} : 32'h0;
  end

  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      state_q     <= IDLE;
      last_snap_q <= 1'b1;
      sc_q        <= '0;
      ns_q        <= '0;
      guard_q     <= '0;
      std_q       <= '0;
      fns_q       <= '0;
    end else begin
      state_q <= state_d;
      if (grant_ofst) begin
        sc_q        <= ofst_sc_i;
        ns_q        <= ofst_ns_i;
        last_snap_q <= 1'b0;
      end
      if (grant_snap) last_snap_q <= 1'b1;
      if (state_q == OWC) guard_q <= GW'(GUARD_CYC - 1);
      else if (state_q == GUARD) guard_q <= guard_q - GW'(1);
      // Read data lands the cycle after its strobe, i.e. while in the next state.
      case (state_q)
        SR1: std_q[79:48] <= bus.m_rdata_i;
        SR2: std_q[47:16] <= bus.m_rdata_i;
`ifdef RTC_SNAP_COHERENT_EN
        SC0: {std_q[15:0], fns_q} <= bus.m_rdata_i;
`else
        SCAP: {std_q[15:0], fns_q} <= bus.m_rdata_i;
`endif
        default: ;
      endcase
    end
  end

`ifdef RTC_SNAP_COHERENT_EN
  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      mism0_q <= 1'b0;
      try_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant_snap) begin
        try_q <= '0;
        err_q <= 1'b0;
      end
      if (state_q == SC1) mism0_q <= (bus.m_rdata_i != std_q[79:48]);
      if (state_q == SCAP && attempt_fail) begin
        if (try_last) err_q <= 1'b1;
        else          try_q <= try_q + TW'(1);
      end
    end
  end

  assign snap_err_o = (state_q == SDONE) && err_q;
`else
  assign snap_err_o = 1'b0;
`endif

  assign bus.m_addr_o  = addr_d;
  assign bus.m_data_o  = data_d;
  assign bus.m_wr_ce_o = wr_d;
  assign bus.m_rd_ce_o = rd_d;
  assign ofst_ack_o    = (state_q == OACK);
  assign snap_done_o   = (state_q == SDONE);
  assign snap_std_o    = std_q;
  assign snap_fns_o    = fns_q;

endmodule
